// File: rtl/management_tx_framer.sv
// Management TX framer: MCU-written frames are buffered, committed or rolled back, then streamed to the PHY TX bus.
// Define MGMT_TX_STATS_EN to build the stat_sent / stat_dropped counters (tied to 0 otherwise).
module management_tx_framer #(
    parameter int DEPTH      = 1024,
    parameter int HDR_DEPTH  = 32,
    parameter int MAX_BYTES  = 1500,
    parameter int IFG_CYCLES = 3
) (
    input  logic        mgmt0_tx_clk,
    input  logic        tx_reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        wr_commit,
    input  logic [10:0] wr_len,
    input  logic        wr_rollback,
    output logic [10:0] wr_size,
    input  logic        tx_ready,
    output logic        tx_bus_start,
    output logic        tx_bus_data_valid,
    output logic [2:0]  tx_bus_bytes_valid,
    output logic [31:0] tx_bus_data,
    output logic        tx_busy,
    output logic [31:0] stat_sent,
    output logic [31:0] stat_dropped
);

    localparam int AW  = $clog2(DEPTH);
    localparam int HAW = $clog2(HDR_DEPTH);
    localparam int GW  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [AW:0]    DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    PTR_ONE  = (AW + 1)'(1);
    localparam logic [10:0]    MAX_LEN  = 11'(MAX_BYTES);
    localparam logic [GW-1:0]  GAP_LAST = GW'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_GAP
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] data_mem [DEPTH];
    logic [10:0] hdr_mem  [HDR_DEPTH];

    // ------------------------------------------------------------------
    // Write side state
    // ------------------------------------------------------------------
    logic [AW:0]  wr_ptr_tmp_q, wr_ptr_tmp_d;
    logic [AW:0]  wr_ptr_commit_q, wr_ptr_commit_d;
    logic [AW:0]  word_cnt_q, word_cnt_d;
    logic         overflow_q, overflow_d;
    logic [10:0]  wr_size_q;
    logic [HAW:0] hdr_wp_q, hdr_rp_q;
    logic         hdr_push, hdr_pop;
    logic         hdr_empty, hdr_full;

    // ------------------------------------------------------------------
    // Read side state
    // ------------------------------------------------------------------
    state_t       state_q, state_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [10:0]  remaining_q, remaining_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic         start_q, start_d;
    logic         valid_q, valid_d;
    logic [2:0]   bv_q, bv_d;
    logic [31:0]  rd_data_q;
    logic         rd_en;
    logic [10:0]  hdr_rd_len;

    logic [AW:0]  used_words;
    logic [AW:0]  free_words;
    logic         buf_full;
    logic         wr_accept;
    logic         overflow_eff;
    logic [AW:0]  word_cnt_eff;
    logic [11:0]  need_words;
    logic         len_ok;
    logic         commit_ok;

    // Occupancy counts uncommitted words too, so the writer can never lap the reader.
    assign used_words   = wr_ptr_tmp_q - rd_ptr_q;
    assign free_words   = DEPTH_W - used_words;
    assign buf_full     = (used_words == DEPTH_W);
    assign wr_accept    = wr_en && !buf_full;
    assign overflow_eff = overflow_q || (wr_en && buf_full);
    assign word_cnt_eff = word_cnt_q + {{AW{1'b0}}, wr_accept};
    assign need_words   = ({1'b0, wr_len} + 12'd3) >> 2;
    assign len_ok       = (wr_len != 11'd0) && (wr_len <= MAX_LEN);
    assign commit_ok    = !overflow_eff && len_ok && (12'(word_cnt_eff) == need_words) && !hdr_full;

    assign hdr_empty  = (hdr_wp_q == hdr_rp_q);
    assign hdr_full   = (hdr_wp_q[HAW] != hdr_rp_q[HAW]) &&
                        (hdr_wp_q[HAW-1:0] == hdr_rp_q[HAW-1:0]);
    assign hdr_rd_len = hdr_mem[hdr_rp_q[HAW-1:0]];

    // Write-side next state; a rejected commit unwinds exactly like a rollback.
    always_comb begin
        wr_ptr_tmp_d    = wr_ptr_tmp_q + {{AW{1'b0}}, wr_accept};
        wr_ptr_commit_d = wr_ptr_commit_q;
        word_cnt_d      = word_cnt_eff;
        overflow_d      = overflow_eff;
        hdr_push        = 1'b0;
        if (wr_rollback) begin
            wr_ptr_tmp_d = wr_ptr_commit_q;
            word_cnt_d   = '0;
            overflow_d   = 1'b0;
        end else if (wr_commit) begin
            word_cnt_d = '0;
            overflow_d = 1'b0;
            if (commit_ok) begin
                wr_ptr_commit_d = wr_ptr_tmp_d;
                hdr_push        = 1'b1;
            end else begin
                wr_ptr_tmp_d = wr_ptr_commit_q;
            end
        end
    end

    // Reader FSM: next state and registered bus outputs.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        start_d     = 1'b0;
        valid_d     = 1'b0;
        bv_d        = 3'd0;
        rd_en       = 1'b0;
        hdr_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hdr_empty && tx_ready) begin
                    hdr_pop     = 1'b1;
                    remaining_d = hdr_rd_len;
                    start_d     = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START, ST_SEND: begin
                if (tx_ready) begin
                    rd_en    = 1'b1;
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (remaining_q <= 11'd4) begin
                        bv_d        = remaining_q[2:0];
                        remaining_d = '0;
                        gap_cnt_d   = '0;
                        state_d     = ST_GAP;
                    end else begin
                        bv_d        = 3'd4;
                        remaining_d = remaining_q - 11'd4;
                        state_d     = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mgmt0_tx_clk) begin
        if (tx_reset) begin
            wr_ptr_tmp_q    <= '0;
            wr_ptr_commit_q <= '0;
            word_cnt_q      <= '0;
            overflow_q      <= 1'b0;
            wr_size_q       <= 11'(DEPTH);
            hdr_wp_q        <= '0;
            hdr_rp_q        <= '0;
            state_q         <= ST_IDLE;
            rd_ptr_q        <= '0;
            remaining_q     <= '0;
            gap_cnt_q       <= '0;
            start_q         <= 1'b0;
            valid_q         <= 1'b0;
            bv_q            <= 3'd0;
        end else begin
            wr_ptr_tmp_q    <= wr_ptr_tmp_d;
            wr_ptr_commit_q <= wr_ptr_commit_d;
            word_cnt_q      <= word_cnt_d;
            overflow_q      <= overflow_d;
            wr_size_q       <= 11'(free_words);
            hdr_wp_q        <= hdr_wp_q + {{HAW{1'b0}}, hdr_push};
            hdr_rp_q        <= hdr_rp_q + {{HAW{1'b0}}, hdr_pop};
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            remaining_q     <= remaining_d;
            gap_cnt_q       <= gap_cnt_d;
            start_q         <= start_d;
            valid_q         <= valid_d;
            bv_q            <= bv_d;
        end
    end

    // Dual-port buffer, read-first; the output register only loads when a word is sent.
    always_ff @(posedge mgmt0_tx_clk) begin
        if (wr_accept) begin
            data_mem[wr_ptr_tmp_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge mgmt0_tx_clk) begin
        if (tx_reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= data_mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge mgmt0_tx_clk) begin
        if (hdr_push) begin
            hdr_mem[hdr_wp_q[HAW-1:0]] <= wr_len;
        end
    end

    assign wr_size            = wr_size_q;
    assign tx_bus_start       = start_q;
    assign tx_bus_data_valid  = valid_q;
    assign tx_bus_bytes_valid = bv_q;
    assign tx_bus_data        = rd_data_q;
    assign tx_busy            = (state_q != ST_IDLE);

`ifdef MGMT_TX_STATS_EN
    logic [31:0] stat_sent_q;
    logic [31:0] stat_dropped_q;
    logic        sent_inc;
    logic        drop_inc;

    assign sent_inc = (state_q != ST_GAP) && (state_d == ST_GAP);
    assign drop_inc = wr_commit && !wr_rollback && !commit_ok;

    always_ff @(posedge mgmt0_tx_clk) begin
        if (tx_reset) begin
            stat_sent_q    <= '0;
            stat_dropped_q <= '0;
        end else begin
            stat_sent_q    <= stat_sent_q + {31'd0, sent_inc};
            stat_dropped_q <= stat_dropped_q + {31'd0, drop_inc};
        end
    end

    assign stat_sent    = stat_sent_q;
    assign stat_dropped = stat_dropped_q;
`else
    assign stat_sent    = '0;
    assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_management_tx_framer.sv
// Directed bench for management_tx_framer: frames are written, committed or rolled back and the TX bus is scoreboarded.
`timescale 1ns/1ps
module tb_management_tx_framer;

    localparam int DEPTH = 1024;
    localparam int IFG   = 3;

    logic        clk = 1'b0;
    logic        tx_reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_commit;
    logic [10:0] wr_len;
    logic        wr_rollback;
    logic [10:0] wr_size;
    logic        tx_ready;
    logic        tx_bus_start;
    logic        tx_bus_data_valid;
    logic [2:0]  tx_bus_bytes_valid;
    logic [31:0] tx_bus_data;
    logic        tx_busy;
    logic [31:0] stat_sent;
    logic [31:0] stat_dropped;

    always #5 clk = ~clk;

    management_tx_framer #(
        .DEPTH      (DEPTH),
        .HDR_DEPTH  (32),
        .MAX_BYTES  (1500),
        .IFG_CYCLES (IFG)
    ) dut (
        .mgmt0_tx_clk       (clk),
        .tx_reset           (tx_reset),
        .wr_en              (wr_en),
        .wr_data            (wr_data),
        .wr_commit          (wr_commit),
        .wr_len             (wr_len),
        .wr_rollback        (wr_rollback),
        .wr_size            (wr_size),
        .tx_ready           (tx_ready),
        .tx_bus_start       (tx_bus_start),
        .tx_bus_data_valid  (tx_bus_data_valid),
        .tx_bus_bytes_valid (tx_bus_bytes_valid),
        .tx_bus_data        (tx_bus_data),
        .tx_busy            (tx_busy),
        .stat_sent          (stat_sent),
        .stat_dropped       (stat_dropped)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp(input int n);
`ifdef MGMT_TX_STATS_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    // Bus monitor: samples on the falling edge, away from the active edge.
    int          cyc = 0;
    int          n_start = 0;
    logic [31:0] q_data[$];
    logic [2:0]  q_bv[$];
    int          q_start_cyc[$];
    int          q_valid_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (tx_bus_start) begin
            n_start++;
            q_start_cyc.push_back(cyc);
        end
        if (tx_bus_data_valid) begin
            q_data.push_back(tx_bus_data);
            q_bv.push_back(tx_bus_bytes_valid);
            q_valid_cyc.push_back(cyc);
        end
    end

    logic [31:0] exp_q[$];
    int exp_sent = 0;
    int exp_drop = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_bv.delete();
        q_start_cyc.delete();
        q_valid_cyc.delete();
        n_start = 0;
        exp_q.delete();
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic commit(input int len);
        wr_commit = 1'b1;
        wr_len    = 11'(len);
        tick();
        wr_commit = 1'b0;
        $display("commit len=%0d", len);
    endtask

    task automatic rollback();
        wr_rollback = 1'b1;
        tick();
        wr_rollback = 1'b0;
        $display("rollback");
    endtask

    task automatic check_frame(input string tag, input int nwords, input logic [2:0] last_bv);
        check($sformatf("%s_nwords", tag), q_data.size(), nwords);
        for (int i = 0; i < nwords && i < q_data.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), q_data[i], exp_q[i]);
            check($sformatf("%s_bv%0d", tag, i), q_bv[i], (i == nwords - 1) ? last_bv : 3'd4);
        end
        $display("frame %s received %0d words", tag, q_data.size());
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_sent"}, stat_sent, stat_exp(exp_sent));
        check({tag, "_dropped"}, stat_dropped, stat_exp(exp_drop));
    endtask

    initial begin
        int cnt;
        logic [31:0] w;

        tx_reset    = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        wr_commit   = 1'b0;
        wr_len      = '0;
        wr_rollback = 1'b0;
        tx_ready    = 1'b0;
        run(3);
        check("rst_wr_size", wr_size, DEPTH);
        check("rst_busy", tx_busy, 0);
        check("rst_valid", tx_bus_data_valid, 0);
        check("rst_start", tx_bus_start, 0);
        check("rst_bv", tx_bus_bytes_valid, 0);
        check("rst_data", tx_bus_data, 0);
        check_stats("rst");
        tx_reset = 1'b0;
        tick();

        // 1: 64-byte frame, back-to-back words, then the interframe gap
        clear_mon();
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = 32'h1000_0000 + 32'(i);
            exp_q.push_back(w);
            write_word(w);
        end
        commit(64);
        run(40);
        exp_sent = 1;
        check_frame("t1", 16, 3'd4);
        check("t1_starts", n_start, 1);
        if (q_valid_cyc.size() == 16 && q_start_cyc.size() == 1) begin
            check("t1_lat", q_valid_cyc[0] - q_start_cyc[0], 1);
            check("t1_burst", q_valid_cyc[15] - q_valid_cyc[0], 15);
        end
        check("t1_wr_size", wr_size, DEPTH);
        check("t1_busy", tx_busy, 0);
        check_stats("t1");

        // 2: odd length frame, then a word-count mismatch that must drop
        clear_mon();
        exp_q.push_back(32'hAABBCCDD);
        exp_q.push_back(32'hEE112233);
        write_word(32'hAABBCCDD);
        write_word(32'hEE112233);
        commit(5);
        run(20);
        exp_sent = 2;
        check_frame("t2a", 2, 3'd1);
        clear_mon();
        write_word(32'h01020304);
        write_word(32'h05060708);
        commit(9);
        run(20);
        exp_drop = 1;
        check("t2b_nwords", q_data.size(), 0);
        check("t2b_starts", n_start, 0);
        check("t2b_wr_size", wr_size, DEPTH);
        check_stats("t2");

        // 3: rollback discards the partial frame
        clear_mon();
        for (int i = 0; i < 4; i++) write_word(32'hDEAD_0000 + 32'(i));
        tick();
        check("t3_wr_size_4", wr_size, DEPTH - 4);
        rollback();
        exp_q.push_back(32'h5555AAAA);
        write_word(32'h5555AAAA);
        commit(4);
        run(20);
        exp_sent = 3;
        check_frame("t3", 1, 3'd4);
        check("t3_wr_size", wr_size, DEPTH);
        check_stats("t3");

        // 4: overflow of the whole buffer
        clear_mon();
        for (int i = 0; i <= DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        check("t4_full", wr_size, 0);
        commit(4);
        check("t4_lag", wr_size, 0);
        tick();
        check("t4_freed", wr_size, DEPTH);
        exp_drop = 2;
        run(10);
        check("t4_nwords", q_data.size(), 0);
        check_stats("t4");

        // 5: tx_ready toggling every cycle
        clear_mon();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w = 32'hC000_0000 + 32'(i * 7);
            exp_q.push_back(w);
            write_word(w);
        end
        commit(64);
        for (int i = 0; i < 80; i++) begin
            tx_ready = (i % 2 == 0);
            tick();
        end
        tx_ready = 1'b1;
        run(10);
        exp_sent = 4;
        check_frame("t5", 16, 3'd4);
        check_stats("t5");

        // 7: interframe gap between two queued frames
        clear_mon();
        tx_ready = 1'b0;
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        write_word(32'h11111111);
        commit(4);
        write_word(32'h22222222);
        commit(4);
        tx_ready = 1'b1;
        run(30);
        exp_sent = 6;
        check_frame("t7", 2, 3'd4);
        check("t7_starts", q_start_cyc.size(), 2);
        if (q_start_cyc.size() == 2 && q_valid_cyc.size() == 2) begin
            check("t7_ifg", q_start_cyc[1] - q_valid_cyc[0], IFG + 1);
        end
        check_stats("t7");

        // 8: maximum-length frames (pointer wrap), over-length, zero length, commit+rollback
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            for (int i = 0; i < 375; i++) begin
                w = {8'(k), 24'(i)};
                exp_q.push_back(w);
                write_word(w);
            end
            commit(1500);
            run(400);
            exp_sent++;
            check_frame($sformatf("t8_max%0d", k), 375, 3'd4);
        end
        clear_mon();
        for (int i = 0; i < 376; i++) write_word(32'(i));
        commit(1501);
        run(20);
        exp_drop = 3;
        check("t8_long_nwords", q_data.size(), 0);
        commit(0);
        run(5);
        exp_drop = 4;
        check("t8_zero_starts", n_start, 0);
        write_word(32'h77777777);
        wr_commit   = 1'b1;
        wr_rollback = 1'b1;
        wr_len      = 11'd4;
        tick();
        wr_commit   = 1'b0;
        wr_rollback = 1'b0;
        $display("commit+rollback len=4");
        run(20);
        check("t8_cr_nwords", q_data.size(), 0);
        check("t8_wr_size", wr_size, DEPTH);
        check_stats("t8");

        // 6: reset in the middle of a frame with two more queued
        clear_mon();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) write_word(32'hF000_0000 + 32'(i));
        commit(64);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) write_word(32'hB000_0000 + 32'(f * 16 + i));
            commit(16);
        end
        tx_ready = 1'b1;
        cnt = 0;
        for (int t = 0; t < 100 && cnt < 8; t++) begin
            tick();
            if (tx_bus_data_valid) cnt++;
        end
        check("t6_reach8", cnt, 8);
        tx_reset = 1'b1;
        tick();
        check("t6_valid_off", tx_bus_data_valid, 0);
        check("t6_busy_off", tx_busy, 0);
        tx_reset = 1'b0;
        clear_mon();
        run(40);
        exp_sent = 0;
        exp_drop = 0;
        check("t6_starts", n_start, 0);
        check("t6_nwords", q_data.size(), 0);
        check("t6_wr_size", wr_size, DEPTH);
        check_stats("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
